// File: rtl/video_timing_pkg.sv
// Shared definitions for the video sync generator.
// Holds the counter width, the 640x480 power-up timing and the timing record
// (active / front porch / sync / polarity per axis) used to describe a raster.
package video_timing_pkg;

    localparam int CW = 12;

    localparam int   DEF_H_ACTIVE = 640;
    localparam int   DEF_H_FP     = 16;
    localparam int   DEF_H_SYNC   = 96;
    localparam int   DEF_V_ACTIVE = 480;
    localparam int   DEF_V_FP     = 10;
    localparam int   DEF_V_SYNC   = 2;
    localparam logic DEF_H_POL    = 1'b0;
    localparam logic DEF_V_POL    = 1'b0;

    typedef struct packed {
        logic [CW-1:0] active;
        logic [CW-1:0] fp;
        logic [CW-1:0] sync;
        logic          pol;
    } axis_timing_t;

    typedef struct packed {
        axis_timing_t h;
        axis_timing_t v;
    } timing_t;

    function automatic timing_t default_timing();
        timing_t t;
        t.h.active = CW'(DEF_H_ACTIVE);
        t.h.fp     = CW'(DEF_H_FP);
        t.h.sync   = CW'(DEF_H_SYNC);
        t.h.pol    = DEF_H_POL;
        t.v.active = CW'(DEF_V_ACTIVE);
        t.v.fp     = CW'(DEF_V_FP);
        t.v.sync   = CW'(DEF_V_SYNC);
        t.v.pol    = DEF_V_POL;
        return t;
    endfunction

endpackage

// File: rtl/video_sync_gen_if.sv
// Configuration handshake bundle for video_sync_gen.
//   cfg_valid / cfg_ready : valid-ready handshake, fields sampled when both high
//   cfg_h_* / cfg_v_*     : active, front porch and sync lengths per axis
//   cfg_h_pol / cfg_v_pol : sync polarity, 1 = active-high
// master = configuration source, slave = the sync generator.
interface video_sync_gen_if #(
    parameter int CW = video_timing_pkg::CW
);
    logic          cfg_valid;
    logic          cfg_ready;
    logic [CW-1:0] cfg_h_active;
    logic [CW-1:0] cfg_h_fp;
    logic [CW-1:0] cfg_h_sync;
    logic [CW-1:0] cfg_v_active;
    logic [CW-1:0] cfg_v_fp;
    logic [CW-1:0] cfg_v_sync;
    logic          cfg_h_pol;
    logic          cfg_v_pol;

    modport master (
        output cfg_valid, cfg_h_active, cfg_h_fp, cfg_h_sync,
               cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_h_pol, cfg_v_pol,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_h_active, cfg_h_fp, cfg_h_sync,
               cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_h_pol, cfg_v_pol,
        output cfg_ready
    );
endinterface

// File: rtl/sync_window_cmp.sv
// Window membership test for one raster axis.
//   count     : current position on the axis
//   start     : first position of the window, one bit wider than count so a
//               start beyond the counter range is representable
//   length    : window length
//   in_window : start <= count < start + length
// The end bound is carried two bits wider than count, so windows that run past
// the counter range simply stop matching instead of wrapping to low counts.
module sync_window_cmp #(
    parameter int CW = video_timing_pkg::CW
) (
    input  logic [CW-1:0] count,
    input  logic [CW:0]   start,
    input  logic [CW-1:0] length,
    output logic          in_window
);

    logic [CW+1:0] count_ext;
    logic [CW+1:0] start_ext;
    logic [CW+1:0] win_end;

    assign count_ext = {2'b00, count};
    assign start_ext = {1'b0, start};
    assign win_end   = start_ext + {2'b00, length};
    assign in_window = (count_ext >= start_ext) && (count_ext < win_end);

endmodule

// File: rtl/video_sync_gen.sv
// Video timing generator driven by an external pixel counter.
//   pixel_clk, rst        : clock and synchronous active-high reset
//   h_count, v_count      : raster position from the upstream counter
//   frame_start           : toggle level, each change marks pixel (0,0)
//   cfg                   : configuration handshake (slave side)
//   hsync, vsync, de      : registered timing outputs
//   pix_x, pix_y          : active-area coordinates, 0 outside the active area
//   sof                   : one-cycle pulse aligned with pixel (0,0)
// Outputs lag the counts by two cycles: compares are registered, then the
// outputs. New configuration waits in a pending register and is promoted to
// the working (shadow) set on a frame edge, so timing never changes mid-frame.
module video_sync_gen
    import video_timing_pkg::*;
#(
    parameter int CW = video_timing_pkg::CW
) (
    input  logic                   pixel_clk,
    input  logic                   rst,
    input  logic [CW-1:0]          h_count,
    input  logic [CW-1:0]          v_count,
    input  logic                   frame_start,
    video_sync_gen_if.slave        cfg,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   de,
    output logic [CW-1:0]          pix_x,
    output logic [CW-1:0]          pix_y,
    output logic                   sof
);

    typedef struct packed {
        logic [CW-1:0] active;
        logic [CW-1:0] fp;
        logic [CW-1:0] sync;
        logic          pol;
    } axis_cfg_t;

    typedef struct packed {
        axis_cfg_t h;
        axis_cfg_t v;
    } cfg_t;

    cfg_t cfg_def;
    cfg_t cfg_in;
    cfg_t shadow_q;
    cfg_t pending_q;
    cfg_t cfg_eff;

    logic fs_d;
    logic frame_edge;
    logic ready_q;
    logic apply_pending;

    logic [CW:0] h_sync_start;
    logic [CW:0] v_sync_start;
    logic        h_in_sync;
    logic        v_in_sync;

    logic          s1_h_act;
    logic          s1_v_act;
    logic          s1_h_sync;
    logic          s1_v_sync;
    logic          s1_h_pol;
    logic          s1_v_pol;
    logic          s1_edge;
    logic [CW-1:0] s1_h;
    logic [CW-1:0] s1_v;

    assign cfg_def = '{
        h: '{active: CW'(DEF_H_ACTIVE), fp: CW'(DEF_H_FP), sync: CW'(DEF_H_SYNC), pol: DEF_H_POL},
        v: '{active: CW'(DEF_V_ACTIVE), fp: CW'(DEF_V_FP), sync: CW'(DEF_V_SYNC), pol: DEF_V_POL}
    };

    assign cfg_in = '{
        h: '{active: cfg.cfg_h_active, fp: cfg.cfg_h_fp, sync: cfg.cfg_h_sync, pol: cfg.cfg_h_pol},
        v: '{active: cfg.cfg_v_active, fp: cfg.cfg_v_fp, sync: cfg.cfg_v_sync, pol: cfg.cfg_v_pol}
    };

    assign frame_edge    = frame_start ^ fs_d;
    // cfg_ready low means pending holds fields waiting for the next frame edge.
    assign apply_pending = frame_edge && !ready_q;
    // The edge cycle carries pixel (0,0) of the new frame, so it already sees
    // the value the shadow is about to take.
    assign cfg_eff       = apply_pending ? pending_q : shadow_q;
    assign cfg.cfg_ready = ready_q;

    // An edge with a full pending register wins; a handshake can only be
    // accepted while ready, i.e. when there is nothing to promote, so a
    // handshake on an edge cycle is simply held for the following edge.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            shadow_q  <= cfg_def;
            pending_q <= cfg_def;
            ready_q   <= 1'b1;
            fs_d      <= 1'b0;
        end else begin
            fs_d <= frame_start;
            if (apply_pending) begin
                shadow_q <= pending_q;
                ready_q  <= 1'b1;
            end else if (ready_q && cfg.cfg_valid) begin
                pending_q <= cfg_in;
                ready_q   <= 1'b0;
            end
        end
    end

    assign h_sync_start = {1'b0, cfg_eff.h.active} + {1'b0, cfg_eff.h.fp};
    assign v_sync_start = {1'b0, cfg_eff.v.active} + {1'b0, cfg_eff.v.fp};

    sync_window_cmp #(.CW(CW)) u_h_win (
        .count     (h_count),
        .start     (h_sync_start),
        .length    (cfg_eff.h.sync),
        .in_window (h_in_sync)
    );

    sync_window_cmp #(.CW(CW)) u_v_win (
        .count     (v_count),
        .start     (v_sync_start),
        .length    (cfg_eff.v.sync),
        .in_window (v_in_sync)
    );

    // Stage 1: compare results, with the polarity that belongs to them.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            s1_h_act  <= 1'b0;
            s1_v_act  <= 1'b0;
            s1_h_sync <= 1'b0;
            s1_v_sync <= 1'b0;
            s1_h_pol  <= 1'b0;
            s1_v_pol  <= 1'b0;
            s1_edge   <= 1'b0;
            s1_h      <= '0;
            s1_v      <= '0;
        end else begin
            s1_h_act  <= h_count < cfg_eff.h.active;
            s1_v_act  <= v_count < cfg_eff.v.active;
            s1_h_sync <= h_in_sync;
            s1_v_sync <= v_in_sync;
            s1_h_pol  <= cfg_eff.h.pol;
            s1_v_pol  <= cfg_eff.v.pol;
            s1_edge   <= frame_edge;
            s1_h      <= h_count;
            s1_v      <= v_count;
        end
    end

    // Stage 2: output registers.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            de    <= 1'b0;
            hsync <= 1'b1;
            vsync <= 1'b1;
            pix_x <= '0;
            pix_y <= '0;
            sof   <= 1'b0;
        end else begin
            de    <= s1_h_act && s1_v_act;
            hsync <= s1_h_sync ? s1_h_pol : ~s1_h_pol;
            vsync <= s1_v_sync ? s1_v_pol : ~s1_v_pol;
            pix_x <= (s1_h_act && s1_v_act) ? s1_h : '0;
            pix_y <= (s1_h_act && s1_v_act) ? s1_v : '0;
            sof   <= s1_edge;
        end
    end

endmodule

// File: tb/tb_video_sync_gen.sv
// Scoreboard bench for video_sync_gen: the stimulus task works out what the
// raster rules say each cycle should produce and queues it; a monitor on the
// falling edge pops and compares when the result is due.
module tb_video_sync_gen;
    import video_timing_pkg::*;

    logic          pixel_clk = 1'b0;
    logic          rst = 1'b1;
    logic [CW-1:0] h_count = '0;
    logic [CW-1:0] v_count = '0;
    logic          frame_start = 1'b0;
    logic          hsync, vsync, de, sof;
    logic [CW-1:0] pix_x, pix_y;

    video_sync_gen_if #(.CW(CW)) cfg_if ();

    video_sync_gen #(.CW(CW)) dut (
        .pixel_clk   (pixel_clk),
        .rst         (rst),
        .h_count     (h_count),
        .v_count     (v_count),
        .frame_start (frame_start),
        .cfg         (cfg_if),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .sof         (sof)
    );

    always #5 pixel_clk = ~pixel_clk;

    typedef struct {
        int due;
        bit de;
        bit hs;
        bit vs;
        bit sof;
        int px;
        int py;
    } exp_t;

    typedef struct {
        int due;
        bit rdy;
    } rdy_t;

    exp_t    exp_q[$];
    rdy_t    rdy_q[$];
    int      checks = 0;
    int      errors = 0;
    int      cyc = 0;

    timing_t m_shadow;
    timing_t m_pend;
    timing_t fields;
    bit      m_ready;
    bit      m_prev_fs;

    always @(posedge pixel_clk) cyc++;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
        end
    endtask

    always @(negedge pixel_clk) begin
        while (rdy_q.size() > 0 && rdy_q[0].due <= cyc) begin : pop_rdy
            rdy_t r;
            r = rdy_q.pop_front();
            if (r.due != cyc) check("cfg_ready_missed", cyc, r.due);
            else check("cfg_ready", int'(cfg_if.cfg_ready), int'(r.rdy));
        end
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin : pop_exp
            exp_t e;
            e = exp_q.pop_front();
            if (e.due != cyc) begin
                check("output_missed", cyc, e.due);
            end else begin
                check("de", int'(de), int'(e.de));
                check("hsync", int'(hsync), int'(e.hs));
                check("vsync", int'(vsync), int'(e.vs));
                check("sof", int'(sof), int'(e.sof));
                check("pix_x", int'(pix_x), e.px);
                check("pix_y", int'(pix_y), e.py);
            end
        end
    end

    // Reference: the raster regions of one axis, evaluated in plain integers.
    function automatic bit in_sync(input int c, input axis_timing_t a);
        int s0;
        int s1;
        s0 = int'(a.active) + int'(a.fp);
        s1 = s0 + int'(a.sync);
        return (c >= s0) && (c < s1);
    endfunction

    task automatic step(input int h, input int v, input bit tog, input bit vld);
        exp_t    e;
        timing_t eff;
        bit      edge_now;
        @(posedge pixel_clk);
        #1;
        h_count = CW'(h);
        v_count = CW'(v);
        if (tog) frame_start = ~frame_start;
        cfg_if.cfg_valid    = vld;
        cfg_if.cfg_h_active = fields.h.active;
        cfg_if.cfg_h_fp     = fields.h.fp;
        cfg_if.cfg_h_sync   = fields.h.sync;
        cfg_if.cfg_h_pol    = fields.h.pol;
        cfg_if.cfg_v_active = fields.v.active;
        cfg_if.cfg_v_fp     = fields.v.fp;
        cfg_if.cfg_v_sync   = fields.v.sync;
        cfg_if.cfg_v_pol    = fields.v.pol;

        rdy_q.push_back('{due: cyc, rdy: m_ready});

        edge_now  = tog;
        // A frame starts with whatever configuration was waiting for it.
        eff = (edge_now && !m_ready) ? m_pend : m_shadow;
        e.due = cyc + 2;
        e.de  = (h < int'(eff.h.active)) && (v < int'(eff.v.active));
        e.hs  = in_sync(h, eff.h) ? eff.h.pol : !eff.h.pol;
        e.vs  = in_sync(v, eff.v) ? eff.v.pol : !eff.v.pol;
        e.sof = edge_now;
        e.px  = e.de ? h : 0;
        e.py  = e.de ? v : 0;
        exp_q.push_back(e);

        if (edge_now && !m_ready) begin
            m_shadow = m_pend;
            m_ready  = 1'b1;
        end else if (m_ready && vld) begin
            m_pend  = fields;
            m_ready = 1'b0;
        end
    endtask

    task automatic drain();
        cfg_if.cfg_valid = 1'b0;
        for (int i = 0; i < 10 && (exp_q.size() > 0 || rdy_q.size() > 0); i++)
            @(posedge pixel_clk);
        @(negedge pixel_clk);
        if (exp_q.size() > 0 || rdy_q.size() > 0) begin
            check("drain_timeout", exp_q.size() + rdy_q.size(), 0);
            exp_q.delete();
            rdy_q.delete();
        end
    endtask

    task automatic do_reset();
        drain();
        rst = 1'b1;
        frame_start = 1'b0;
        repeat (2) @(posedge pixel_clk);
        @(negedge pixel_clk);
        check("rst_de", int'(de), 0);
        check("rst_sof", int'(sof), 0);
        check("rst_hsync", int'(hsync), 1);
        check("rst_vsync", int'(vsync), 1);
        check("rst_pix_x", int'(pix_x), 0);
        check("rst_pix_y", int'(pix_y), 0);
        check("rst_cfg_ready", int'(cfg_if.cfg_ready), 1);
        m_shadow  = default_timing();
        m_pend    = default_timing();
        m_ready   = 1'b1;
        m_prev_fs = 1'b0;
        rst = 1'b0;
    endtask

    task automatic rand_fields();
        fields.h.active = CW'($urandom_range(0, 1023));
        fields.h.fp     = CW'($urandom_range(0, 300));
        fields.h.sync   = CW'($urandom_range(0, 300));
        fields.h.pol    = 1'($urandom_range(0, 1));
        fields.v.active = CW'($urandom_range(0, 1023));
        fields.v.fp     = CW'($urandom_range(0, 300));
        fields.v.sync   = CW'($urandom_range(0, 300));
        fields.v.pol    = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) fields.h.fp = CW'($urandom_range(3000, 4095));
    endtask

    initial begin
        fields = default_timing();
        cfg_if.cfg_valid = 1'b0;
        do_reset();

        // Defaults: full line sweep, then the vertical sync neighbourhood.
        step(0, 0, 1'b1, 1'b0);
        for (int h = 1; h < 800; h++) step(h, 0, 1'b0, 1'b0);
        for (int v = 470; v < 525; v++) step($urandom_range(0, 799), v, 1'b0, 1'b0);
        for (int v = 488; v < 494; v++) step(700, v, 1'b0, 1'b0);

        // Falling toggle is a frame edge too.
        step(0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(i + 1, 0, 1'b0, 1'b0);

        // Mid-frame handshake: wider line only from the next frame on.
        fields.h.active = CW'(800);
        step(100, 5, 1'b0, 1'b1);
        fields.h.active = CW'(5);
        step(101, 5, 1'b0, 1'b1);
        for (int h = 600; h < 820; h++) step(h, 10, 1'b0, 1'b0);
        step(0, 0, 1'b1, 1'b0);
        for (int h = 600; h < 820; h++) step(h, 0, 1'b0, 1'b0);

        // Handshake on the edge cycle, with a sync window beyond the counter range.
        fields = default_timing();
        fields.h.fp   = CW'(4000);
        fields.h.sync = CW'(200);
        step(0, 0, 1'b1, 1'b1);
        for (int h = 640; h < 900; h++) step(h, 1, 1'b0, 1'b0);
        step(0, 0, 1'b1, 1'b0);
        for (int h = 1; h < 800; h++) step(h, 0, 1'b0, 1'b0);
        for (int h = 3900; h < 4096; h++) step(h, 0, 1'b0, 1'b0);

        // Random frames with random configuration traffic.
        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < 150; i++) begin
                rand_fields();
                if (i == 0) step(0, 0, 1'b1, ($urandom_range(0, 3) == 0));
                else step($urandom_range(0, 2047), $urandom_range(0, 2047), 1'b0,
                          ($urandom_range(0, 15) == 0));
            end
        end

        // Reset while a configuration is pending.
        fields = default_timing();
        step(0, 0, 1'b1, 1'b0);
        fields.h.active = CW'(300);
        step(5, 5, 1'b0, 1'b1);
        step(6, 5, 1'b0, 1'b0);
        step(7, 5, 1'b0, 1'b0);
        do_reset();
        fields = default_timing();
        step(0, 0, 1'b1, 1'b0);
        for (int h = 1; h < 800; h++) step(h, 0, 1'b0, 1'b0);

        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_sync_gen.md
VIDEO_SYNC_GEN -- requirements
Module: video_sync_gen

Interface
REQ-001 The block SHALL have parameter CW, default 12: width of all counter and timing fields.
REQ-002 The block SHALL have port pixel_clk  input  1: sole clock, all logic rising-edge.
REQ-003 The block SHALL have port rst  input  1: synchronous, active-high reset.
REQ-004 The block SHALL have ports h_count, v_count  input  CW: raster position from the upstream pixel counter.
REQ-005 The block SHALL have port frame_start  input  1: toggle level; every change marks a new frame (h_count=v_count=0 that cycle).
REQ-006 The block SHALL have ports cfg_valid input 1, cfg_ready output 1: configuration handshake.
REQ-007 The block SHALL have ports cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_v_active, cfg_v_fp, cfg_v_sync  input  CW: timing fields, sampled on handshake.
REQ-008 The block SHALL have ports cfg_h_pol, cfg_v_pol  input  1: sync polarity, 1 = active-high.
REQ-009 The block SHALL have ports hsync, vsync, de  output  1: registered video timing.
REQ-010 The block SHALL have ports pix_x, pix_y  output  CW: active-area coordinates, valid when de=1, else 0.
REQ-011 The block SHALL have port sof  output  1: single-cycle pulse aligned with pixel (0,0).

Function
REQ-012 Outputs SHALL lag h_count/v_count by exactly 2 cycles: stage 1 registers the compares, stage 2 registers the outputs.
REQ-013 Regions per axis SHALL be: active [0, A); front porch [A, A+FP); sync [A+FP, A+FP+S); back porch beyond that.
REQ-014 de SHALL be 1 iff h_count < h_active AND v_count < v_active.
REQ-015 hsync SHALL equal h_pol when h_count is in the h sync window, else ~h_pol; vsync likewise on v_count with v_pol.
REQ-016 Window bounds SHALL be computed in CW+1 bits; a bound exceeding 2^CW-1 never matches, with no wrap.
REQ-017 The frame edge SHALL be frame_start XOR its 1-cycle delayed copy; sof SHALL pulse 2 cycles after that edge.
REQ-018 Config SHALL use a pending/shadow pair: cfg_valid&&cfg_ready latches the fields into pending and drops cfg_ready.
REQ-019 On the next frame edge, pending SHALL copy to shadow and cfg_ready SHALL return to 1 the following cycle.
REQ-020 Compares SHALL use only the shadow; a shadow change SHALL never take effect mid-frame.
REQ-021 Simultaneous handshake and frame edge: the edge SHALL apply the old pending (if any); the new fields SHALL be held for the next edge.
REQ-022 While cfg_ready=0, cfg_valid SHALL be ignored and cfg fields SHALL not be sampled.

Reset
REQ-023 On rst=1 the shadow and pending registers SHALL load 640x480 defaults (640/16/96, 480/10/2, both polarities 0).
REQ-024 On rst=1 the block SHALL drive de=0, sof=0, pix_x=pix_y=0, hsync=vsync=1 (inactive for polarity 0), cfg_ready=1, and clear the pipeline and edge detector.
REQ-025 A mid-frame reset SHALL discard pending config; outputs resume from the counts 2 cycles after release.

Structure
REQ-026 Package video_timing_pkg SHALL hold CW, the 640x480 default constants, and a timing record typedef (active, fp, sync, pol per axis).
REQ-027 One sub-module, sync_window_cmp (count, start, length -> in_window), SHALL be instantiated twice, once per axis.

Verification
REQ-028 Defaults, h_count sweeps 0..799: de high for counts 0..639; hsync low for counts 656..751; all outputs 2 cycles late.
REQ-029 v_count=490..491 with pol 0 -> vsync=0; v_count=492 -> vsync=1.
REQ-030 Handshake h_active=800 mid-frame -> cfg_ready=0; de still ends at 640; next frame de ends at 800; cfg_ready=1 one cycle after the edge.
REQ-031 frame_start toggles 0->1 then 1->0 -> exactly one sof pulse per toggle, each 2 cycles after its edge, with pix_x=pix_y=0.
REQ-032 cfg_h_fp=4000, cfg_h_sync=200 (CW=12) -> hsync never asserts, no wrap to low counts.
REQ-033 rst asserted with config pending -> cfg_ready=1, pending lost, defaults active after release.
